dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port 16x16 data memory between two requesters: the CPU memory stage and the UART host port used for load and debug.
- The CPU has priority by default. A wait counter bounds UART starvation: once it expires, the UART is forced one slot and the pipeline stalls for one cycle.
- Sits between the memory stage and the data memory, and drives the memory's address, write-enable and write-data pins.

Parameters:
ADDR_W, 4, memory address width (16 entries)
DATA_W, 16, data word width
MAX_WAIT, 4, number of consecutive blocked UART cycles before a forced UART slot (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  memory stage performs an access this cycle (load or store)
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data, equal to mem_rdata
cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold the memory stage
uart_req  in  1  UART access pending; held with addr/we/wdata stable until uart_gnt
uart_we  in  1  1 = write, 0 = read
uart_addr  in  ADDR_W  UART address
uart_wdata  in  DATA_W  UART write data
uart_gnt  out  1  UART access issued to memory this cycle
uart_rdata  out  DATA_W  registered read data
uart_rvalid  out  1  one-cycle pulse, uart_rdata valid (reads only)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Reset is asynchronous and active-low: reset=0 clears the internal state immediately, with no clock edge needed.
- Reset values:
  - state=IDLE, wait_cnt=0, uart_rvalid=0, uart_rdata=0.
  - While reset=0, uart_gnt=0, cpu_stall=0 and mem_we=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - uart_req=1 and cpu_req=0: grant the UART this cycle (uart_gnt=1), then go to RESP.
  - uart_req=1 and cpu_req=1: the CPU is served, wait_cnt becomes 1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - cpu_req=0: grant the UART, wait_cnt becomes 0, go to RESP.
  - cpu_req=1 and wait_cnt<MAX_WAIT: the CPU is served, wait_cnt increments.
  - cpu_req=1 and wait_cnt==MAX_WAIT: forced slot. The UART is granted, cpu_stall=1, mem_we takes uart_we, wait_cnt becomes 0, go to RESP.
  - uart_req dropping while in WAIT is a protocol violation. The arbiter returns to IDLE and clears wait_cnt.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - uart_rvalid=1 only if the granted access was a read; uart_rdata holds mem_rdata captured at the grant edge.
  - uart_req is ignored in this cycle: there are no back-to-back UART grants, so the CPU always gets at least one slot in between.
  - The CPU is served normally.
- Memory mux (combinational):
  - When uart_gnt=1, mem_addr/mem_wdata/mem_we come from the UART.
  - Otherwise they come from the CPU, with mem_we = cpu_req & cpu_we.
  - When there is no request, mem_we=0 and mem_addr follows cpu_addr.
- cpu_rdata = mem_rdata at all times. It is meaningful only when cpu_stall=0.
- cpu_stall is asserted only on the forced slot. Its maximum duty is 1 cycle in every MAX_WAIT+2 cycles.
- Latency:
  - UART write commits at the clock edge that ends the grant cycle.
  - UART read data appears with uart_rvalid one cycle after uart_gnt.
  - Worst-case UART wait from request to grant is MAX_WAIT+1 cycles.
- wait_cnt is 4 bits wide and saturates at MAX_WAIT; it never wraps.
- Reset asserted mid-transaction (WAIT or RESP): the pending UART access is dropped, with no grant and no rvalid. A write granted at the same edge that reset asserts is not guaranteed to commit.

Test Plan:
- UART write only: reset released, cpu_req=0, uart_req=1, we=1, addr=4'h3, wdata=16'hBEEF -> uart_gnt=1 that cycle, mem_we=1 with mem_addr=3; then a UART read of addr 3 -> uart_rvalid pulses one cycle after gnt with uart_rdata=16'hBEEF.
- CPU priority: cpu_req=1 continuously (loads), uart read request held, MAX_WAIT=4 -> UART is blocked 4 cycles; on the 5th cycle uart_gnt=1 and cpu_stall=1 for exactly one cycle; next cycle cpu_stall=0 and uart_rvalid=1.
- Idle gap: CPU store to addr 5 with data 16'h1234, then cpu_req drops while the UART is waiting in WAIT with wait_cnt=2 -> grant in the first idle cycle with no stall; wait_cnt returns to 0.
- No back-to-back grants: uart_req held high across two reads with cpu_req=0 -> grants occur on cycles N and N+2, never N+1.
- Reset mid-WAIT: reset driven low asynchronously between clock edges while in WAIT -> uart_gnt, cpu_stall, mem_we and uart_rvalid go to 0 immediately; after release the state is IDLE and the next request behaves as in scenario 1.
- CPU store/load through arbiter: store 16'hA5A5 to addr 4'hF, then load addr 4'hF -> cpu_rdata=16'hA5A5, cpu_stall=0, and no UART signals toggle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port 16x16 data memory.
// The CPU memory stage has priority. A bounded wait counter forces a UART
// slot after MAX_WAIT blocked cycles, stalling the pipeline for one cycle.
module dmem_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_gnt,
    output logic [DATA_W-1:0] uart_rdata,
    output logic              uart_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arbStateT;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    arbStateT          state;
    arbStateT          nextState;
    logic [3:0]        waitCnt;
    logic [3:0]        nextWait;
    logic              gntRaw;
    logic              stallRaw;
    logic              uartGnt;
    logic              uartRvalidQ;
    logic [DATA_W-1:0] uartRdataQ;

    // State and wait-counter registers; reset clears them without a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWait;
        end
    end

    // Next-state, wait-counter update and raw grant/stall decisions.
    always_comb begin
        nextState = state;
        nextWait  = waitCnt;
        gntRaw    = 1'b0;
        stallRaw  = 1'b0;
        case (state)
            IDLE: begin
                if (uart_req && !cpu_req) begin
                    gntRaw    = 1'b1;
                    nextState = RESP;
                end else if (uart_req && cpu_req) begin
                    nextWait  = 4'd1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (!uart_req) begin
                    // Requester abandoned its access: give up and start over.
                    nextWait  = 4'd0;
                    nextState = IDLE;
                end else if (!cpu_req) begin
                    gntRaw    = 1'b1;
                    nextWait  = 4'd0;
                    nextState = RESP;
                end else if (waitCnt < MAX_CNT) begin
                    nextWait = waitCnt + 4'd1;
                end else begin
                    // Starvation bound reached: steal this slot from the CPU.
                    gntRaw    = 1'b1;
                    stallRaw  = 1'b1;
                    nextWait  = 4'd0;
                    nextState = RESP;
                end
            end
            RESP: begin
                // UART request is ignored here so the CPU always gets a slot.
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
                nextWait  = 4'd0;
            end
        endcase
    end

    // Memory pin mux; grant, stall and write enable are held low while in reset.
    always_comb begin
        uartGnt   = gntRaw & reset;
        cpu_stall = stallRaw & reset;
        if (uartGnt) begin
            mem_addr  = uart_addr;
            mem_wdata = uart_wdata;
            mem_we    = uart_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_req & cpu_we & reset;
        end
    end

    // Capture UART read data at the grant edge and pulse rvalid for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uartRvalidQ <= 1'b0;
            uartRdataQ  <= '0;
        end else begin
            uartRvalidQ <= uartGnt & ~uart_we;
            if (uartGnt && !uart_we) begin
                uartRdataQ <= mem_rdata;
            end
        end
    end

    assign uart_gnt    = uartGnt;
    assign uart_rvalid = uartRvalidQ;
    assign uart_rdata  = uartRdataQ;
    assign cpu_rdata   = mem_rdata;

endmodule
